// File: rtl/br_pkg.sv
// Shared types for the branch resolution unit: condition codes, 2-bit counter
// encodings and the condition/counter helper functions.
package br_pkg;

   localparam logic [2:0] CC_NE  = 3'b000;
   localparam logic [2:0] CC_EQ  = 3'b001;
   localparam logic [2:0] CC_GT  = 3'b010;
   localparam logic [2:0] CC_LT  = 3'b011;
   localparam logic [2:0] CC_GTE = 3'b100;
   localparam logic [2:0] CC_LTE = 3'b101;
   localparam logic [2:0] CC_OV  = 3'b110;
   localparam logic [2:0] CC_UNC = 3'b111;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bht_ctr_t;

   function automatic logic cc_eval(input logic [2:0] cc, input logic z,
                                    input logic v, input logic n);
      logic r;
      case (cc)
         CC_NE:   r = ~z;
         CC_EQ:   r = z;
         CC_GT:   r = ~z & ~n;
         CC_LT:   r = n;
         CC_GTE:  r = z | ~n;
         CC_LTE:  r = n | z;
         CC_OV:   r = v;
         default: r = 1'b1;
      endcase
      return r;
   endfunction

   // Saturating step toward ST on taken, toward SNT on not-taken.
   function automatic bht_ctr_t ctr_next(input bht_ctr_t c, input logic taken);
      bht_ctr_t r;
      r = c;
      if (taken && c != ST)       r = bht_ctr_t'(c + 2'd1);
      else if (!taken && c != SNT) r = bht_ctr_t'(c - 2'd1);
      return r;
   endfunction

endpackage

// File: rtl/br_bht.sv
// Untagged table of 2-bit saturating counters: one combinational read port,
// one synchronous update port, synchronous active-low reset to WNT.
module br_bht
   import br_pkg::*;
#(
   parameter int BHT_DEPTH = 16,
   localparam int IDX_W = $clog2(BHT_DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] rd_idx_i,
   output logic             rd_taken_o,
   input  logic             upd_en_i,
   input  logic [IDX_W-1:0] upd_idx_i,
   input  logic             upd_taken_i
);

   bht_ctr_t cnt_q [BHT_DEPTH];

   // Read sees the pre-update value on a same-entry write.
   assign rd_taken_o = cnt_q[rd_idx_i][1];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_DEPTH; i++) cnt_q[i] <= WNT;
      end else if (upd_en_i) begin
         cnt_q[upd_idx_i] <= ctr_next(cnt_q[upd_idx_i], upd_taken_i);
      end
   end

endmodule

// File: rtl/br_resolve_unit.sv
// Branch resolution: architectural Z/V/N flags from NUM_LANES lanes, EX
// condition evaluation, BHT prediction/mispredict. Optional BR_STATS_EN adds counters.
module br_resolve_unit
   import br_pkg::*;
#(
   parameter int NUM_LANES = 2,
   parameter int BHT_DEPTH = 16,
   parameter int PC_W      = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 stall_EX,
   input  logic [NUM_LANES-1:0] clk_z_EX,
   input  logic [NUM_LANES-1:0] clk_nv_EX,
   input  logic [NUM_LANES-1:0] zr_in,
   input  logic [NUM_LANES-1:0] ov_in,
   input  logic [NUM_LANES-1:0] neg_in,
   input  logic                 br_instr_EX,
   input  logic                 jmp_imm_EX,
   input  logic                 jmp_reg_EX,
   input  logic [2:0]           cc_EX,
   input  logic [PC_W-1:0]      pc_EX,
   input  logic                 pred_taken_EX,
   input  logic [PC_W-1:0]      pc_IF,
   output logic                 pred_taken_IF,
   output logic                 flow_change_EX,
   output logic                 mispredict_EX,
   output logic                 zr_flag,
   output logic                 ov_flag,
   output logic                 neg_flag
`ifdef BR_STATS_EN
  ,output logic [31:0]          br_cnt,
   output logic [31:0]          mispred_cnt
`endif
);

   localparam int IDX_W = $clog2(BHT_DEPTH);

   logic zr_q, zr_d, ov_q, ov_d, neg_q, neg_d;
   logic br_upd;

   // Lanes are in program order, so a later (higher) lane overrides.
   always_comb begin
      zr_d  = zr_q;
      ov_d  = ov_q;
      neg_d = neg_q;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (clk_z_EX[i]) zr_d = zr_in[i];
         if (clk_nv_EX[i]) begin
            ov_d  = ov_in[i];
            neg_d = neg_in[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         zr_q  <= 1'b0;
         ov_q  <= 1'b0;
         neg_q <= 1'b0;
      end else if (!stall_EX) begin
         zr_q  <= zr_d;
         ov_q  <= ov_d;
         neg_q <= neg_d;
      end
   end

   assign zr_flag  = zr_q;
   assign ov_flag  = ov_q;
   assign neg_flag = neg_q;

   // Condition uses registered flags only; same-cycle updates land next cycle.
   assign flow_change_EX = br_instr_EX ? cc_eval(cc_EX, zr_q, ov_q, neg_q)
                                       : (jmp_imm_EX | jmp_reg_EX);
   assign br_upd         = br_instr_EX & ~stall_EX;
   assign mispredict_EX  = br_upd & (flow_change_EX != pred_taken_EX);

   br_bht #(.BHT_DEPTH(BHT_DEPTH)) u_bht (
      .clk         (clk),
      .rst_n       (rst_n),
      .rd_idx_i    (pc_IF[IDX_W-1:0]),
      .rd_taken_o  (pred_taken_IF),
      .upd_en_i    (br_upd),
      .upd_idx_i   (pc_EX[IDX_W-1:0]),
      .upd_taken_i (flow_change_EX)
   );

   generate
      if (PC_W > IDX_W) begin : g_pc_hi
         logic unused_pc_hi;
         assign unused_pc_hi = ^{pc_EX[PC_W-1:IDX_W], pc_IF[PC_W-1:IDX_W]};
      end
   endgenerate

`ifdef BR_STATS_EN
   logic [31:0] br_cnt_q, mispred_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         br_cnt_q      <= '0;
         mispred_cnt_q <= '0;
      end else begin
         if (br_upd)        br_cnt_q      <= br_cnt_q + 32'd1;
         if (mispredict_EX) mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
   end

   assign br_cnt      = br_cnt_q;
   assign mispred_cnt = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_br_resolve_unit.sv
// Directed bench for br_resolve_unit; expectations are queued as stimulus is
// driven and popped against DUT outputs. Covers BR_STATS_EN when defined.
module tb_br_resolve_unit;

   localparam int NL   = 2;
   localparam int PC_W = 16;

   logic            clk = 1'b0;
   logic            rst_n, stall_EX;
   logic [NL-1:0]   clk_z_EX, clk_nv_EX, zr_in, ov_in, neg_in;
   logic            br_instr_EX, jmp_imm_EX, jmp_reg_EX, pred_taken_EX;
   logic [2:0]      cc_EX;
   logic [PC_W-1:0] pc_EX, pc_IF;
   logic            pred_taken_IF, flow_change_EX, mispredict_EX;
   logic            zr_flag, ov_flag, neg_flag;
`ifdef BR_STATS_EN
   logic [31:0]     br_cnt, mispred_cnt;
   logic [31:0]     br_cnt_snap;
`endif

   always #5 clk = ~clk;

   br_resolve_unit #(.NUM_LANES(NL), .BHT_DEPTH(16), .PC_W(PC_W)) dut (
      .clk(clk), .rst_n(rst_n), .stall_EX(stall_EX),
      .clk_z_EX(clk_z_EX), .clk_nv_EX(clk_nv_EX),
      .zr_in(zr_in), .ov_in(ov_in), .neg_in(neg_in),
      .br_instr_EX(br_instr_EX), .jmp_imm_EX(jmp_imm_EX), .jmp_reg_EX(jmp_reg_EX),
      .cc_EX(cc_EX), .pc_EX(pc_EX), .pred_taken_EX(pred_taken_EX), .pc_IF(pc_IF),
      .pred_taken_IF(pred_taken_IF), .flow_change_EX(flow_change_EX),
      .mispredict_EX(mispredict_EX),
      .zr_flag(zr_flag), .ov_flag(ov_flag), .neg_flag(neg_flag)
`ifdef BR_STATS_EN
     ,.br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
`endif
   );

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } sb_t;

   sb_t sb_q[$];
   int  checks = 0;
   int  errors = 0;

   task automatic push(input string tag, input logic [31:0] exp);
      sb_t e;
      e.tag = tag;
      e.exp = exp;
      sb_q.push_back(e);
   endtask

   task automatic pop_chk(input logic [31:0] obs);
      sb_t e;
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $error("FAIL sb_empty observed=%0h expected=<entry>", obs);
      end else begin
         e = sb_q.pop_front();
         assert (obs === e.exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stall_EX = 0; clk_z_EX = '0; clk_nv_EX = '0;
      zr_in = '0; ov_in = '0; neg_in = '0;
      br_instr_EX = 0; jmp_imm_EX = 0; jmp_reg_EX = 0;
      cc_EX = 3'b000; pred_taken_EX = 0; pc_EX = '0; pc_IF = '0;
   endtask

   logic [7:0] cc_exp;

   initial begin
      idle();
      rst_n = 0;
      tick(); tick();
      rst_n = 1;

      // Reset state: every entry weakly not-taken, flags clear
      for (int p = 0; p < 16; p++) begin
         pc_IF = PC_W'(p);
         push($sformatf("rst_pred_%0d", p), 0);
         #1 pop_chk(pred_taken_IF);
      end
      push("rst_z", 0); pop_chk(zr_flag);
      push("rst_v", 0); pop_chk(ov_flag);
      push("rst_n", 0); pop_chk(neg_flag);

      // Set Z=1 via lane0
      clk_z_EX = 2'b01; zr_in = 2'b01;
      tick();
      push("z_set", 1); pop_chk(zr_flag);

      // Both lanes update Z; lane1 (0) wins. Same-cycle BEQ sees old Z=1.
      clk_z_EX = 2'b11; zr_in = 2'b01;
      br_instr_EX = 1; cc_EX = 3'b001; pc_EX = 16'h0003; pred_taken_EX = 1;
      push("beq_old_z", 1); push("beq_nomisp", 0);
      #1 pop_chk(flow_change_EX); pop_chk(mispredict_EX);
      tick();
      idle();
      push("z_lane1_wins", 0); pop_chk(zr_flag);
      pc_IF = 16'h0003;
      push("pc3_pred", 1);
      #1 pop_chk(pred_taken_IF);

      // N=1, V=1 via lane0
      clk_nv_EX = 2'b01; ov_in = 2'b01; neg_in = 2'b01;
      tick();
      idle();
      push("v_set", 1); pop_chk(ov_flag);
      push("n_set", 1); pop_chk(neg_flag);

      // Condition sweep under stall so no counter moves; Z=0 N=1 V=1
      cc_exp = 8'b1110_1001; // bit k = expected for cc k
      stall_EX = 1; br_instr_EX = 1; pc_EX = 16'h0007;
      for (int c = 0; c < 8; c++) begin
         cc_EX = 3'(c);
         push($sformatf("cc_%0d", c), {31'b0, cc_exp[c]});
         #1 pop_chk(flow_change_EX);
      end
      idle();

      // Taken branches at pc 5; pc_IF 0x15 aliases entry 5
      pc_IF = 16'h0015;
      br_instr_EX = 1; cc_EX = 3'b111; pc_EX = 16'h0005; pred_taken_EX = 0;
      push("t1_misp", 1); push("t1_pred_before", 0);
      #1 pop_chk(mispredict_EX); pop_chk(pred_taken_IF);
      tick();                                  // 01 -> 10
      push("t1_pred_after", 1); pop_chk(pred_taken_IF);
      pred_taken_EX = 1;
      push("t2_nomisp", 0);
      #1 pop_chk(mispredict_EX);
      tick();                                  // 10 -> 11
      tick();                                  // 11 -> 11
      // Two not-taken (EQ with Z=0): 11 -> 10 keeps pred 1, then 10 -> 01
      cc_EX = 3'b001;
      push("nt1_misp", 1);
      #1 pop_chk(mispredict_EX);
      tick();
      push("sat_pred", 1); pop_chk(pred_taken_IF);
      tick();
      push("nt2_pred", 0); pop_chk(pred_taken_IF);

      // Stalled mispredicting branch plus flag updates: nothing moves
      stall_EX = 1; cc_EX = 3'b111; pred_taken_EX = 0;
      clk_z_EX = 2'b01; zr_in = 2'b01;
      clk_nv_EX = 2'b10; ov_in = 2'b00; neg_in = 2'b00;
      push("stall_fc", 1); push("stall_nomisp", 0);
      #1 pop_chk(flow_change_EX); pop_chk(mispredict_EX);
      tick();
      push("stall_z", 0);    pop_chk(zr_flag);
      push("stall_v", 1);    pop_chk(ov_flag);
      push("stall_n", 1);    pop_chk(neg_flag);
      push("stall_pred", 0); pop_chk(pred_taken_IF);
      idle();
      pc_IF = 16'h0015;

      // Register jump: flow change, never mispredict
`ifdef BR_STATS_EN
      br_cnt_snap = br_cnt;
`endif
      jmp_reg_EX = 1;
      push("jmp_fc", 1); push("jmp_nomisp", 0);
      #1 pop_chk(flow_change_EX); pop_chk(mispredict_EX);
      tick();
`ifdef BR_STATS_EN
      push("jmp_brcnt", br_cnt_snap); pop_chk(br_cnt);
`endif
      idle();
      pc_IF = 16'h0005;

      // Raise entry 5 to WT, then reset with a pending taken branch and Z update
      br_instr_EX = 1; cc_EX = 3'b111; pc_EX = 16'h0005;
      tick();
      push("pre_rst_pred", 1); pop_chk(pred_taken_IF);
      clk_z_EX = 2'b01; zr_in = 2'b01;
      rst_n = 0;
      tick();
      rst_n = 1;
      idle();
      pc_IF = 16'h0005;
      #1;
      push("mid_rst_pred5", 0); pop_chk(pred_taken_IF);
      pc_IF = 16'h0003;
      push("mid_rst_pred3", 0);
      #1 pop_chk(pred_taken_IF);
      push("mid_rst_z", 0); pop_chk(zr_flag);
      push("mid_rst_v", 0); pop_chk(ov_flag);
      push("mid_rst_n", 0); pop_chk(neg_flag);
`ifdef BR_STATS_EN
      push("mid_rst_brcnt", 0);  pop_chk(br_cnt);
      push("mid_rst_miscnt", 0); pop_chk(mispred_cnt);
`endif

      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
